// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// reset PC default and the NOP word.
package mips_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: drives the instruction-memory handshake, holds
// the fetched word for decode, and retires stale requests after a redirect.
module fetch_seq
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        pc_err
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  drop_addr, drop_addr_n;
  logic         if_valid_n;
  logic [31:0]  if_pc_n, if_ins_n;
  logic         pc_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      drop_addr <= '0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_ins    <= NOP_WORD;
      pc_err    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop_addr <= drop_addr_n;
      if_valid  <= if_valid_n;
      if_pc     <= if_pc_n;
      if_ins    <= if_ins_n;
      pc_err    <= pc_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_addr_n = drop_addr;
    if_valid_n  = if_valid;
    if_pc_n     = if_pc;
    if_ins_n    = if_ins;
    pc_err_n    = redirect_valid && (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      pc_n       = {redirect_pc[31:2], 2'b00};
      if_valid_n = 1'b0;
      // A request already in flight must be allowed to complete before the
      // new target is presented, so remember where it was pointing.
      if (state != S_DROP) begin
        if (imem_req && !imem_ack) begin
          drop_addr_n = imem_addr;
          state_n     = S_DROP;
        end else begin
          state_n = S_FETCH;
        end
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            if_ins_n   = imem_rdata;
            if_pc_n    = pc;
            if_valid_n = 1'b1;
            pc_n       = pc + 32'd4;
            state_n    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if (imem_ack) begin
              if_ins_n   = imem_rdata;
              if_pc_n    = pc;
              if_valid_n = 1'b1;
              pc_n       = pc + 32'd4;
            end else begin
              if_valid_n = 1'b0;
              state_n    = S_FETCH;
            end
          end
        end
        S_DROP: begin
          if (imem_ack) state_n = S_FETCH;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = (state == S_DROP) ? drop_addr : pc;
    if (!rst) begin
      case (state)
        S_FETCH: imem_req = 1'b1;
        S_DROP:  imem_req = 1'b1;
        S_HOLD:  imem_req = !stall;
        default: imem_req = 1'b0;
      endcase
    end
  end

endmodule
